countdown_timer: RTL

//  Loadable down-counter: the count-down companion of the team's enable-driven up-counter.

---
 rtl/countdown_timer_pkg.sv | 15 +
 rtl/countdown_timer_if.sv | 26 ++
 rtl/countdown_timer_tick_prescaler.sv | 35 +++
 rtl/countdown_timer.sv | 110 +++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and default widths for the countdown timer and its prescaler.
//   DEF_WIDTH      default count width
//   DEF_PRESCALE_W default prescale divider width
//   state_t        timer FSM states
package countdown_timer_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_PRESCALE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_t;

endpackage

// File: rtl/countdown_timer_if.sv
// Load handshake bundle for the countdown timer.
//   load_valid  master -> slave  load request
//   load_ready  slave  -> master timer can accept a load
//   load_value  master -> slave  start count
//   auto_reload master -> slave  periodic (1) / one-shot (0), sampled at load
//   prescale    master -> slave  tick divider, sampled at load
interface countdown_timer_if #(
    parameter int unsigned WIDTH      = countdown_timer_pkg::DEF_WIDTH,
    parameter int unsigned PRESCALE_W = countdown_timer_pkg::DEF_PRESCALE_W
);
    logic                  load_valid;
    logic                  load_ready;
    logic [WIDTH-1:0]      load_value;
    logic                  auto_reload;
    logic [PRESCALE_W-1:0] prescale;

    modport master (
        output load_valid, load_value, auto_reload, prescale,
        input  load_ready
    );

    modport slave (
        input  load_valid, load_value, auto_reload, prescale,
        output load_ready
    );
endinterface

// File: rtl/countdown_timer_tick_prescaler.sv
// Enable-gated prescaler: tick fires every prescale+1 enabled cycles.
//   CLK, RST  clock, synchronous active-high reset
//   clear     restart the divider from 0
//   enable    advance the divider; tick is suppressed while low
//   prescale  divider terminal value
//   tick      combinational, high on the enabled cycle the divider hits prescale
module tick_prescaler
    import countdown_timer_pkg::*;
#(
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] prescaler;

    assign tick = enable && (prescaler == prescale);

    // Divider counts enabled cycles and wraps on tick.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prescaler <= '0;
        end else if (clear || tick) begin
            prescaler <= '0;
        end else if (enable) begin
            prescaler <= prescaler + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaled ticks, one-shot or periodic reload.
//   CLK, RST        clock, synchronous active-high reset
//   ld              load handshake (slave side)
//   enable          pauses prescaler and count when low
//   abort           stop a run and return to IDLE, count held
//   counter         current count
//   underflow_flag  one-cycle pulse when a tick arrives with the count at 0
//   busy            high while running
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic             CLK,
    input  logic             RST,
    countdown_timer_if.slave ld,
    input  logic             enable,
    input  logic             abort,
    output logic [WIDTH-1:0] counter,
    output logic             underflow_flag,
    output logic             busy
);

    state_t                state, state_next;
    logic [WIDTH-1:0]      counter_next;
    logic [WIDTH-1:0]      reload_reg, reload_next;
    logic                  auto_reg, auto_next;
    logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
    logic                  flag_next;
    logic                  clear_c;
    logic                  tick;

    tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (clear_c),
        .enable   (enable),
        .prescale (prescale_reg),
        .tick     (tick)
    );

    // State and datapath registers; status outputs follow the next state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= ST_IDLE;
            counter        <= '0;
            reload_reg     <= '0;
            auto_reg       <= 1'b0;
            prescale_reg   <= '0;
            underflow_flag <= 1'b0;
            busy           <= 1'b0;
            ld.load_ready  <= 1'b1;
        end else begin
            state          <= state_next;
            counter        <= counter_next;
            reload_reg     <= reload_next;
            auto_reg       <= auto_next;
            prescale_reg   <= prescale_next;
            underflow_flag <= flag_next;
            busy           <= (state_next == ST_RUN);
            ld.load_ready  <= (state_next == ST_IDLE);
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_next    = state;
        counter_next  = counter;
        reload_next   = reload_reg;
        auto_next     = auto_reg;
        prescale_next = prescale_reg;
        flag_next     = 1'b0;
        clear_c       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (ld.load_valid) begin
                    state_next    = ST_RUN;
                    counter_next  = ld.load_value;
                    reload_next   = ld.load_value;
                    auto_next     = ld.auto_reload;
                    prescale_next = ld.prescale;
                    clear_c       = 1'b1;
                end
            end
            ST_RUN: begin
                // Abort outranks a coinciding expiry, so no flag in that case.
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (tick) begin
                    if (counter != '0) begin
                        counter_next = counter - WIDTH'(1);
                    end else begin
                        flag_next = 1'b1;
                        if (auto_reg) begin
                            counter_next = reload_reg;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule
